// File: rtl/tt_sweep_capture_if.sv
// Handshake/bus bundle for tt_sweep_capture; the DUT connects through the master modport.
// Signals exp_tt/mismatch exist only when TT_CHECK_EN is defined.
interface tt_sweep_capture_if #(
    parameter int unsigned N_IN = 4
);
    localparam int unsigned TT_W = 2 ** N_IN;

    logic            start;
    logic            busy;
    logic [N_IN-1:0] x;
    logic            y0;
    logic [TT_W-1:0] tt;
    logic            tt_valid;
    logic            tt_ready;
`ifdef TT_CHECK_EN
    logic [TT_W-1:0] exp_tt;
    logic            mismatch;

    modport master (
        input  start, y0, tt_ready, exp_tt,
        output busy, x, tt, tt_valid, mismatch
    );
    modport slave (
        output start, y0, tt_ready, exp_tt,
        input  busy, x, tt, tt_valid, mismatch
    );
`else
    modport master (
        input  start, y0, tt_ready,
        output busy, x, tt, tt_valid
    );
    modport slave (
        output start, y0, tt_ready,
        input  busy, x, tt, tt_valid
    );
`endif
endinterface

// File: rtl/tt_sweep_capture.sv
// Exhaustive input sweep of an N_IN-input cone with truth-table capture and valid/ready output.
// Optional feature macro TT_CHECK_EN adds a registered compare against an expected table.
module tt_sweep_capture #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned LAT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    tt_sweep_capture_if.master bus
);
    localparam int unsigned TT_W = 2 ** N_IN;
    localparam int unsigned PD   = (LAT > 0) ? LAT : 1;
    localparam logic [2:0]  DRAIN_LAST = 3'(LAT - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [2:0]      drain_q, drain_d;
    logic [PD-1:0]   pv_q;
    logic [N_IN-1:0] pidx_q [PD];
    logic            cap_v;
    logic [N_IN-1:0] cap_idx;
`ifdef TT_CHECK_EN
    logic [TT_W-1:0] exp_q, exp_d;
    logic            mis_q, mis_d;
`endif

    // The capture point is the tail of the LAT-deep pipe, or the driven vector itself when LAT=0.
    always_comb begin
        if (LAT == 0) begin
            cap_v   = (state_q == DRIVE);
            cap_idx = x_q;
        end else begin
            cap_v   = pv_q[PD-1];
            cap_idx = pidx_q[PD-1];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        tt_d    = tt_q;
        drain_d = drain_q;
`ifdef TT_CHECK_EN
        exp_d   = exp_q;
        mis_d   = mis_q;
`endif
        if (cap_v) tt_d[cap_idx] = bus.y0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    x_d     = '0;
                    tt_d    = '0;
`ifdef TT_CHECK_EN
                    exp_d   = bus.exp_tt;
`endif
                end
            end
            DRIVE: begin
                if (x_q == '1) begin
                    x_d     = '0;
                    drain_d = '0;
                    if (LAT == 0) state_d = DONE;
                    else          state_d = DRAIN;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = DONE;
                else                       drain_d = drain_q + 3'd1;
            end
            DONE: begin
                if (bus.tt_ready) begin
                    state_d = IDLE;
`ifdef TT_CHECK_EN
                    mis_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TT_CHECK_EN
        if (state_d == DONE && state_q != DONE) mis_d = (tt_d != exp_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            tt_q    <= '0;
            drain_q <= '0;
`ifdef TT_CHECK_EN
            exp_q   <= '0;
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tt_q    <= tt_d;
            drain_q <= drain_d;
`ifdef TT_CHECK_EN
            exp_q   <= exp_d;
            mis_q   <= mis_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            for (int unsigned k = 0; k < PD; k++) pidx_q[k] <= '0;
        end else begin
            for (int unsigned k = PD - 1; k > 0; k--) begin
                pv_q[k]   <= pv_q[k-1];
                pidx_q[k] <= pidx_q[k-1];
            end
            pv_q[0]   <= (state_q == DRIVE);
            pidx_q[0] <= x_q;
        end
    end

    assign bus.x        = x_q;
    assign bus.busy     = (state_q == DRIVE) || (state_q == DRAIN);
    assign bus.tt       = tt_q;
    assign bus.tt_valid = (state_q == DONE);
`ifdef TT_CHECK_EN
    assign bus.mismatch = mis_q;
`endif
endmodule
